ha_operand_feeder: RTL and testbench
====================================

# ha_operand_feeder

Bit-serial operand sequencer that sits directly upstream of the half-adder core (`tt_um_haahalia` datapath). It latches two WIDTH-bit operands on a start pulse and presents one bit pair per cycle to the half adder. It collects the returned sum and carry bits into result vectors, then signals completion with a one-cycle done pulse. Operands come from the `ui_in` pins; results go to `uo_out`.

## Interface
- WIDTH, 4, operand width and number of feed cycles; legal range 2..8
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request pulse; sampled only in IDLE
- op_a  in  WIDTH  operand A; latched on an accepted start
- op_b  in  WIDTH  operand B; latched on an accepted start
- busy  out  1  high in FEED and DONE
- ha_a  out  1  current A bit to the half adder
- ha_b  out  1  current B bit to the half adder
- ha_valid  out  1  high while a bit pair is presented
- ha_sum  in  1  half-adder sum; combinational response to ha_a/ha_b
- ha_carry  in  1  half-adder carry; combinational response to ha_a/ha_b
- sum_vec  out  WIDTH  collected sum bits; bit i from pair i
- carry_vec  out  WIDTH  collected carry bits
- done  out  1  one-cycle completion pulse
- parity  out  1  XOR-reduce of sum_vec; see Configuration

## Operation
- Reset: when rst is high at a clock edge, the block enters IDLE and clears all state.
  - Output values in reset: busy=0, ha_a=0, ha_b=0, ha_valid=0, sum_vec=0, carry_vec=0, done=0, parity=0.
  - Synchronous reset overrides all other inputs, including a start in the same cycle.
- States:
  - IDLE: on start=1, latch op_a/op_b into registers, set idx=0, clear sum_vec/carry_vec, go to FEED.
  - FEED: drive ha_a=a_reg[idx], ha_b=b_reg[idx], ha_valid=1. At each edge, capture ha_sum into sum_vec[idx] and ha_carry into carry_vec[idx]. When idx==WIDTH-1, go to DONE; otherwise increment idx.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- The idx counter is ceil(log2(WIDTH)) bits wide and does not wrap. The FEED exit happens at WIDTH-1.
- start is ignored in FEED and DONE; no queuing. Operand changes after acceptance have no effect.
- sum_vec/carry_vec hold their values after done until the next accepted start clears them.
- ha_a/ha_b are 0 whenever ha_valid=0.
- Resulting function: sum_vec = a XOR b and carry_vec = a AND b, computed bitwise by the downstream half adder.

## Timing
- start is sampled high at edge N; IDLE→FEED at N.
- ha_valid is high from after edge N through edge N+WIDTH, i.e. WIDTH cycles. Bit i is presented in cycle N+1+i.
- Final capture happens at edge N+WIDTH; done is high in cycle N+WIDTH+1.
- Earliest next accepted start: edge N+WIDTH+2. Total throughput is one operation per WIDTH+2 cycles.
- The half adder is combinational, so there is zero response latency: ha_sum/ha_carry are sampled on the same edge that ends the bit's presentation.
- Reset asserted mid-FEED takes effect at the next edge:
  - no done pulse is produced;
  - vectors are cleared;
  - the block is in IDLE on the following cycle.

## Configuration
- HA_FEEDER_PARITY_EN defined:
  - parity is a register loaded with ^sum_vec (including the final captured bit) at the FEED→DONE edge, so it is valid in the same cycle as done.
  - It holds until the next accepted start or reset, both of which clear it to 0.
- HA_FEEDER_PARITY_EN undefined: the parity port remains present and is tied to 0; no parity register is generated.

## Test plan
- Basic case: reset 2 cycles, then op_a=4'b1010, op_b=4'b0110, start for 1 cycle.
  - ha_valid is high for 4 cycles with (ha_a,ha_b) = (0,0),(1,1),(0,1),(1,0).
  - done arrives at cycle start+5 with sum_vec=4'b1100, carry_vec=4'b0010.
- All ones: op_a=4'hF, op_b=4'hF → sum_vec=4'h0, carry_vec=4'hF, done exactly one cycle, busy low the next cycle.
- Start while busy: a second start with op_a=4'h3 during FEED is ignored.
  - The result matches the first operands.
  - Exactly one done pulse is produced.
- Reset mid-operation: rst for 1 cycle at the second FEED cycle.
  - No done pulse occurs.
  - sum_vec=carry_vec=0, busy=0, ha_valid=0 on the next cycle.
  - A new start with op_a=4'h5, op_b=4'h0 yields sum_vec=4'h5.
- Back-to-back operations: start at the earliest legal cycle after done, with (4'h1,4'h0) then (4'h0,4'h0).
  - Results are 4'h1/4'h0 and then 4'h0/4'h0.
  - With HA_FEEDER_PARITY_EN, parity=1 then 0. Without it, parity is always 0.

Source files
------------

// File: rtl/ha_operand_feeder.sv
// Bit-serial operand sequencer feeding a combinational half adder, one bit pair per cycle.
// Optional parity register enabled by defining HA_FEEDER_PARITY_EN.
module ha_operand_feeder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             ha_a,
   output logic             ha_b,
   output logic             ha_valid,
   input  logic             ha_sum,
   input  logic             ha_carry,
   output logic [WIDTH-1:0] sum_vec,
   output logic [WIDTH-1:0] carry_vec,
   output logic             done,
   output logic             parity
);

   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FEED = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             feeding;
   logic             accept;

   assign feeding  = (state == FEED);
   assign accept   = (state == IDLE) && start;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign ha_valid = feeding;
   assign ha_a     = feeding & a_reg[idx];
   assign ha_b     = feeding & b_reg[idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_vec   <= '0;
         carry_vec <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  idx       <= '0;
                  sum_vec   <= '0;
                  carry_vec <= '0;
                  state     <= FEED;
               end
            end
            FEED: begin
               // half adder is combinational: its response is captured on the edge ending the bit
               sum_vec[idx]   <= ha_sum;
               carry_vec[idx] <= ha_carry;
               if (idx == LAST) begin
                  state <= DONE;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HA_FEEDER_PARITY_EN
   logic             parity_reg;
   logic [WIDTH-1:0] sum_final;

   // includes the bit being captured on the final edge
   always_comb begin
      sum_final      = sum_vec;
      sum_final[idx] = ha_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_reg <= 1'b0;
      end else if (accept) begin
         parity_reg <= 1'b0;
      end else if (feeding && (idx == LAST)) begin
         parity_reg <= ^sum_final;
      end
   end

   assign parity = parity_reg;
`else
   assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_ha_operand_feeder.sv
// Randomized self-checking bench for ha_operand_feeder with a behavioural half adder downstream.
module tb_ha_operand_feeder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         busy, ha_a, ha_b, ha_valid, ha_sum, ha_carry, done, parity;
   logic [W-1:0] sum_vec, carry_vec;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign ha_sum   = ha_a ^ ha_b;
   assign ha_carry = ha_a & ha_b;

   ha_operand_feeder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .ha_a(ha_a), .ha_b(ha_b), .ha_valid(ha_valid),
      .ha_sum(ha_sum), .ha_carry(ha_carry), .sum_vec(sum_vec),
      .carry_vec(carry_vec), .done(done), .parity(parity)
   );

   function automatic logic exp_parity(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef HA_FEEDER_PARITY_EN
      return ($countones(a ^ b) % 2) == 1;
`else
      return 1'b0;
`endif
   endfunction

   // Drives one start and observes until done (or the cycle budget expires).
   // Returns at the negedge of the done cycle; cycle 1 is the first cycle after the start edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke_start,
                         output logic [W-1:0] pa, output logic [W-1:0] pb, output int nvalid,
                         output int done_cyc, output logic [W-1:0] sv, output logic [W-1:0] cv,
                         output logic par, output int stray);
      pa = '0; pb = '0; nvalid = 0; done_cyc = -1; sv = 'x; cv = 'x; par = 1'bx; stray = 0;
      @(negedge clk);
      op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= W + 4; c++) begin
         if (ha_valid) begin
            if (nvalid < W) begin
               pa[nvalid] = ha_a;
               pb[nvalid] = ha_b;
            end
            nvalid++;
         end else if (ha_a || ha_b) begin
            stray++;
         end
         if (done) begin
            done_cyc = c; sv = sum_vec; cv = carry_vec; par = parity;
            break;
         end
         if (poke_start && c == 2) begin
            start = 1'b1; op_a = 4'h3; op_b = 4'h3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op_a = 4'hF; op_b = 4'hF;
      repeat (2) @(negedge clk);
      rst = 1'b0; start = 1'b0;
      vectors++;
      if ({busy, ha_a, ha_b, ha_valid, done, parity, sum_vec, carry_vec} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b ha_a=%b ha_b=%b valid=%b done=%b par=%b sum=%h carry=%h, required all 0",
                  busy, ha_a, ha_b, ha_valid, done, parity, sum_vec, carry_vec);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] pa, pb, sv, cv; logic par; int nv, dc, st;
      run_op(4'b1010, 4'b0110, 1'b0, pa, pb, nv, dc, sv, cv, par, st);
      vectors++;
      if (nv !== W || pa !== 4'b1010 || pb !== 4'b0110 || st !== 0) begin
         miscompares++;
         $display("FAIL basic_pairs: nvalid=%0d a_bits=%b b_bits=%b stray=%0d, required 4 1010 0110 0", nv, pa, pb, st);
      end
      vectors++;
      if (dc !== W + 1 || sv !== 4'b1100 || cv !== 4'b0010 || par !== exp_parity(4'b1010, 4'b0110)) begin
         miscompares++;
         $display("FAIL basic_result: done_cyc=%0d sum=%b carry=%b par=%b, required 5 1100 0010 %b",
                  dc, sv, cv, par, exp_parity(4'b1010, 4'b0110));
      end
   endtask

   task automatic test_all_ones();
      logic [W-1:0] pa, pb, sv, cv; logic par; int nv, dc, st;
      run_op(4'hF, 4'hF, 1'b0, pa, pb, nv, dc, sv, cv, par, st);
      vectors++;
      if (dc !== W + 1 || sv !== 4'h0 || cv !== 4'hF) begin
         miscompares++;
         $display("FAIL all_ones_result: done_cyc=%0d sum=%h carry=%h, required 5 0 f", dc, sv, cv);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL all_ones_after: done=%b busy=%b, required 0 0", done, busy);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (sum_vec !== 4'h0 || carry_vec !== 4'hF || parity !== exp_parity(4'hF, 4'hF)) begin
         miscompares++;
         $display("FAIL all_ones_hold: sum=%h carry=%h par=%b, required 0 f %b", sum_vec, carry_vec, parity,
                  exp_parity(4'hF, 4'hF));
      end
   endtask

   task automatic test_start_while_busy();
      logic [W-1:0] pa, pb, sv, cv; logic par; int nv, dc, st, extra;
      run_op(4'b1001, 4'b0101, 1'b1, pa, pb, nv, dc, sv, cv, par, st);
      vectors++;
      if (dc !== W + 1 || sv !== 4'b1100 || cv !== 4'b0001 || pa !== 4'b1001 || pb !== 4'b0101) begin
         miscompares++;
         $display("FAIL busy_start_result: done_cyc=%0d sum=%b carry=%b a_bits=%b b_bits=%b, required 5 1100 0001 1001 0101",
                  dc, sv, cv, pa, pb);
      end
      extra = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      vectors++;
      if (extra !== 0) begin
         miscompares++;
         $display("FAIL busy_start_single: extra busy/done cycles=%0d, required 0", extra);
      end
   endtask

   task automatic test_reset_mid_feed();
      logic [W-1:0] pa, pb, sv, cv; logic par; int nv, dc, st, dones;
      @(negedge clk);
      op_a = 4'hA; op_b = 4'hF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (sum_vec !== '0 || carry_vec !== '0 || busy !== 1'b0 || ha_valid !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_state: sum=%h carry=%h busy=%b valid=%b done=%b, required 0 0 0 0 0",
                  sum_vec, carry_vec, busy, ha_valid, done);
      end
      dones = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (done) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_nodone: done pulses=%0d, required 0", dones);
      end
      run_op(4'h5, 4'h0, 1'b0, pa, pb, nv, dc, sv, cv, par, st);
      vectors++;
      if (dc !== W + 1 || sv !== 4'h5 || cv !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_mid_restart: done_cyc=%0d sum=%h carry=%h, required 5 5 0", dc, sv, cv);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pa, pb, sv, cv; logic par; int nv, dc, st;
      run_op(4'h1, 4'h0, 1'b0, pa, pb, nv, dc, sv, cv, par, st);
      vectors++;
      if (dc !== W + 1 || sv !== 4'h1 || cv !== 4'h0 || par !== exp_parity(4'h1, 4'h0)) begin
         miscompares++;
         $display("FAIL b2b_first: done_cyc=%0d sum=%h carry=%h par=%b, required 5 1 0 %b",
                  dc, sv, cv, par, exp_parity(4'h1, 4'h0));
      end
      run_op(4'h0, 4'h0, 1'b0, pa, pb, nv, dc, sv, cv, par, st);
      vectors++;
      if (dc !== W + 1 || sv !== 4'h0 || cv !== 4'h0 || par !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second: done_cyc=%0d sum=%h carry=%h par=%b, required 5 0 0 0", dc, sv, cv, par);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, pa, pb, sv, cv; logic par; int nv, dc, st;
      for (int n = 0; n < 24; n++) begin
         a = W'($urandom);
         b = W'($urandom);
         run_op(a, b, 1'b0, pa, pb, nv, dc, sv, cv, par, st);
         vectors++;
         if (dc !== W + 1 || nv !== W || pa !== a || pb !== b || st !== 0 ||
             sv !== (a ^ b) || cv !== (a & b) || par !== exp_parity(a, b)) begin
            miscompares++;
            $display("FAIL random_op[%0d]: a=%h b=%h done_cyc=%0d nvalid=%0d a_bits=%h b_bits=%h stray=%0d sum=%h carry=%h par=%b, required 5 4 %h %h 0 %h %h %b",
                     n, a, b, dc, nv, pa, pb, st, sv, cv, par, a, b, a ^ b, a & b, exp_parity(a, b));
         end
         if (($urandom % 2) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_start_while_busy();
      test_reset_mid_feed();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
